// File: rtl/seg_scan_encoder_if.sv
// Application-side bus of the 8-digit 7-segment scan encoder: display contents
// in, HC595 word and frame status out.
interface seg_scan_encoder_if;
  logic [31:0] Disp_Data;
  logic [7:0]  Disp_En;
  logic [7:0]  Disp_Dp;
  logic        Disp_Load;
  logic [15:0] Data;
  logic        Frame_Done;
  logic        Pending;

  modport master (
    output Disp_Data, Disp_En, Disp_Dp, Disp_Load,
    input  Data, Frame_Done, Pending
  );

  modport slave (
    input  Disp_Data, Disp_En, Disp_Dp, Disp_Load,
    output Data, Frame_Done, Pending
  );
endinterface

// File: rtl/seg_scan_encoder.sv
// Dynamic-scan encoder for an 8-digit 7-segment display with frame-boundary double buffering.
// Optional leading-zero suppression: define SEG_LEADING_ZERO_BLANK_EN.
module seg_scan_encoder #(
  parameter int SCAN_CNT_MAX   = 50000,
  parameter int BLANK_CYCLES   = 16,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int SEL_ACTIVE_LOW = 1
) (
  input  logic                Clk,
  input  logic                Reset,
  seg_scan_encoder_if.slave   disp
);

  localparam int                CNT_W    = $clog2(SCAN_CNT_MAX);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SCAN_CNT_MAX - 1);
  localparam logic [CNT_W-1:0]  CNT_LIT  = CNT_W'(BLANK_CYCLES);
  localparam logic [7:0]        SEG_OFF  = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [7:0]        SEL_OFF  = (SEL_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

  // Active-high a..g pattern for a hex nibble (bit 0 = a).
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      default: seg = 7'h71;
    endcase
    return seg;
  endfunction

  function automatic logic [7:0] seg_polarity(input logic [7:0] seg_on);
    return (SEG_ACTIVE_LOW != 0) ? ~seg_on : seg_on;
  endfunction

  function automatic logic [7:0] sel_polarity(input logic [7:0] sel_on);
    return (SEL_ACTIVE_LOW != 0) ? ~sel_on : sel_on;
  endfunction

  logic [CNT_W-1:0] scan_cnt;
  logic [2:0]       digit_idx;
  logic             terminal;
  logic             boundary;

  logic [31:0]      shadow_data, pend_data;
  logic [7:0]       shadow_en, shadow_dp, pend_en, pend_dp;
  logic             pending_q;

  logic [7:0]       lz_mask;
  logic [3:0]       nib_p0;
  logic             show_p0;
  logic [15:0]      word_p0;

  logic [15:0]      data_p1;
  logic             frame_done_p1;

  assign terminal = (scan_cnt == CNT_LAST);
  assign boundary = terminal && (digit_idx == 3'd7);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      scan_cnt  <= '0;
      digit_idx <= '0;
    end else if (terminal) begin
      scan_cnt  <= '0;
      digit_idx <= digit_idx + 3'd1;
    end else begin
      scan_cnt  <= scan_cnt + CNT_W'(1);
    end
  end

  // A load on the boundary itself bypasses the pending stage so it shows this frame.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      shadow_data <= '0;
      shadow_en   <= '0;
      shadow_dp   <= '0;
      pend_data   <= '0;
      pend_en     <= '0;
      pend_dp     <= '0;
      pending_q   <= 1'b0;
    end else if (boundary) begin
      if (disp.Disp_Load) begin
        shadow_data <= disp.Disp_Data;
        shadow_en   <= disp.Disp_En;
        shadow_dp   <= disp.Disp_Dp;
      end else if (pending_q) begin
        shadow_data <= pend_data;
        shadow_en   <= pend_en;
        shadow_dp   <= pend_dp;
      end
      pending_q <= 1'b0;
    end else if (disp.Disp_Load) begin
      pend_data <= disp.Disp_Data;
      pend_en   <= disp.Disp_En;
      pend_dp   <= disp.Disp_Dp;
      pending_q <= 1'b1;
    end
  end

`ifdef SEG_LEADING_ZERO_BLANK_EN
  // Walk down from digit 7; enabled zero digits without dp are hidden until
  // the first significant enabled digit. Digit 0 is never hidden.
  always_comb begin
    logic leading;
    lz_mask = '0;
    leading = 1'b1;
    for (int i = 7; i >= 1; i--) begin
      if (shadow_en[i]) begin
        if (leading && (shadow_data[4*i +: 4] == 4'h0) && !shadow_dp[i]) begin
          lz_mask[i] = 1'b1;
        end else begin
          leading = 1'b0;
        end
      end
    end
  end
`else
  assign lz_mask = '0;
`endif

  // Stage p0: word for the current slot position, from shadow contents
  assign nib_p0  = shadow_data[{digit_idx, 2'b00} +: 4];
  assign show_p0 = (scan_cnt >= CNT_LIT) && shadow_en[digit_idx] && !lz_mask[digit_idx];
  assign word_p0 = show_p0
                 ? {seg_polarity({shadow_dp[digit_idx], hex_to_seg(nib_p0)}),
                    sel_polarity(8'b1 << digit_idx)}
                 : {SEG_OFF, SEL_OFF};

  // Stage p1: registered outputs to the HC595 driver
  always_ff @(posedge Clk) begin
    if (Reset) begin
      data_p1       <= {SEG_OFF, SEL_OFF};
      frame_done_p1 <= 1'b0;
    end else begin
      data_p1       <= word_p0;
      frame_done_p1 <= boundary;
    end
  end

  assign disp.Data       = data_p1;
  assign disp.Frame_Done = frame_done_p1;
  assign disp.Pending    = pending_q;

endmodule
